rf_wport_scheduler: RTL and testbench

// Shares the single register-file write port (we3/ad3/wd3) between three writers:
//   - the pipeline writeback (WB)
//   - the long-latency unit result (LU, mul/div)
//   - the debug port (DBG)

---
 rtl/rf_wport_scheduler.sv | 140 ++++++++++++++
 tb/tb_rf_wport_scheduler.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wport_scheduler.sv
// Arbitrates the single register-file write port between writeback, the long-latency unit
// and the debug port, and tracks pending long-latency destinations to drive the decode stall.
module rf_wport_scheduler #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int STARVE_MAX = 8,
    parameter int CNT_W      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              lu_issue,
    input  logic [ADDR_W-1:0] lu_issue_rd,
    input  logic              lu_valid,
    input  logic [ADDR_W-1:0] lu_rd,
    input  logic [DATA_W-1:0] lu_data,
    output logic              lu_ready,
    input  logic              dbg_valid,
    input  logic [ADDR_W-1:0] dbg_rd,
    input  logic [DATA_W-1:0] dbg_data,
    output logic              dbg_ready,
    input  logic              dec_valid,
    input  logic [ADDR_W-1:0] dec_rs1,
    input  logic [ADDR_W-1:0] dec_rs2,
    input  logic [ADDR_W-1:0] dec_rd,
    input  logic              dec_use1,
    input  logic              dec_use2,
    input  logic              dec_used,
    output logic              hazard_stall,
    output logic              pipe_freeze,
    output logic              we3,
    output logic [ADDR_W-1:0] ad3,
    output logic [DATA_W-1:0] wd3,
    output logic              sched_state,
    output logic [CNT_W-1:0]  starve_cnt
);

    localparam int NREG = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_FREEZE = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NREG-1:0]   pending_q, pending_d;
    logic              gnt_wb, gnt_lu, gnt_dbg;

    // Handshakes: a requester holds valid (and its rd/data) stable until it sees ready in
    // the same cycle; the transfer happens on valid & ready. WB has no ready: it is only
    // held off by pipe_freeze and re-presents its request itself.
    always_comb begin
        gnt_wb  = 1'b0;
        gnt_lu  = 1'b0;
        gnt_dbg = 1'b0;
        if (!rst) begin
            gnt_wb  = wb_valid && (state_q == ST_NORMAL);
            gnt_lu  = lu_valid && !gnt_wb;
            gnt_dbg = dbg_valid && !gnt_wb && !gnt_lu;
        end
    end

    always_comb begin
        we3 = 1'b0;
        ad3 = '0;
        wd3 = '0;
        if (gnt_wb) begin
            ad3 = wb_rd;
            wd3 = wb_data;
            we3 = (wb_rd != '0);
        end else if (gnt_lu) begin
            ad3 = lu_rd;
            wd3 = lu_data;
            we3 = (lu_rd != '0);
        end else if (gnt_dbg) begin
            ad3 = dbg_rd;
            wd3 = dbg_data;
            we3 = (dbg_rd != '0);
        end
    end

    assign lu_ready    = gnt_lu;
    assign dbg_ready   = gnt_dbg;
    assign pipe_freeze = !rst && (state_q == ST_FREEZE);

    // Stall looks only at the registered scoreboard, so it drops the cycle after completion.
    assign hazard_stall = !rst && dec_valid &&
                          ((dec_use1 && pending_q[dec_rs1]) ||
                           (dec_use2 && pending_q[dec_rs2]) ||
                           (dec_used && pending_q[dec_rd]));

    // Clear before set so a same-cycle issue on the completing register keeps it pending.
    always_comb begin
        pending_d = pending_q;
        if (gnt_lu) begin
            pending_d[lu_rd] = 1'b0;
        end
        if (lu_issue) begin
            pending_d[lu_issue_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_comb begin
        cnt_d = '0;
        if (lu_valid && !gnt_lu) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        end
    end

    // Enter FREEZE as the count reaches the limit, so the freeze cycle is the next one.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_NORMAL: if (cnt_d == CNT_MAX) state_d = ST_FREEZE;
            ST_FREEZE: state_d = ST_NORMAL;
            default:   state_d = ST_NORMAL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_NORMAL;
            cnt_q     <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
        end
    end

    assign sched_state = state_q;
    assign starve_cnt  = cnt_q;

endmodule

// File: tb/tb_rf_wport_scheduler.sv
// Directed and randomized checks of rf_wport_scheduler against a cycle-level reference
// model of the arbitration, scoreboard and starvation rules.
module tb_rf_wport_scheduler;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int STARVE_MAX = 8;
    localparam int CNT_W = 4;
    localparam int NREG = 32;

    logic clk = 1'b0;
    logic rst;
    logic wb_valid, lu_issue, lu_valid, dbg_valid, dec_valid;
    logic [ADDR_W-1:0] wb_rd, lu_issue_rd, lu_rd, dbg_rd, dec_rs1, dec_rs2, dec_rd;
    logic [DATA_W-1:0] wb_data, lu_data, dbg_data;
    logic dec_use1, dec_use2, dec_used;
    logic lu_ready, dbg_ready, hazard_stall, pipe_freeze, we3, sched_state;
    logic [ADDR_W-1:0] ad3;
    logic [DATA_W-1:0] wd3;
    logic [CNT_W-1:0] starve_cnt;

    always #5 clk = ~clk;

    rf_wport_scheduler #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .lu_issue(lu_issue), .lu_issue_rd(lu_issue_rd),
        .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data), .lu_ready(lu_ready),
        .dbg_valid(dbg_valid), .dbg_rd(dbg_rd), .dbg_data(dbg_data), .dbg_ready(dbg_ready),
        .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
        .dec_use1(dec_use1), .dec_use2(dec_use2), .dec_used(dec_used),
        .hazard_stall(hazard_stall), .pipe_freeze(pipe_freeze),
        .we3(we3), .ad3(ad3), .wd3(wd3),
        .sched_state(sched_state), .starve_cnt(starve_cnt)
    );

    int n_checks = 0;
    int n_pass = 0;
    int n_fail = 0;

    // Reference model state: which registers await an LU result, how many cycles in a row
    // the LU has been refused, and whether this cycle is the forced LU-priority cycle.
    bit [NREG-1:0] m_pend;
    int m_starve;
    bit m_freeze;
    bit m_wb_g, m_lu_g, m_dbg_g;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        wb_valid = 0; wb_rd = '0; wb_data = '0;
        lu_issue = 0; lu_issue_rd = '0;
        lu_valid = 0; lu_rd = '0; lu_data = '0;
        dbg_valid = 0; dbg_rd = '0; dbg_data = '0;
        dec_valid = 0; dec_rs1 = '0; dec_rs2 = '0; dec_rd = '0;
        dec_use1 = 0; dec_use2 = 0; dec_used = 0;
    endtask

    // Mid-cycle: compare every combinational output against the model.
    task automatic look();
        bit exp_stall;
        bit exp_we;
        logic [ADDR_W-1:0] exp_ad;
        logic [DATA_W-1:0] exp_wd;
        #3;
        if (rst) begin
            m_wb_g = 0; m_lu_g = 0; m_dbg_g = 0;
            check("rst_we3", 32'(we3), 0);
            check("rst_ad3", 32'(ad3), 0);
            check("rst_wd3", wd3, 0);
            check("rst_lu_ready", 32'(lu_ready), 0);
            check("rst_dbg_ready", 32'(dbg_ready), 0);
            check("rst_stall", 32'(hazard_stall), 0);
            check("rst_freeze", 32'(pipe_freeze), 0);
        end else begin
            m_wb_g  = wb_valid && !m_freeze;
            m_lu_g  = lu_valid && !m_wb_g;
            m_dbg_g = dbg_valid && !m_wb_g && !m_lu_g;
            exp_ad = m_wb_g ? wb_rd : m_lu_g ? lu_rd : dbg_rd;
            exp_wd = m_wb_g ? wb_data : m_lu_g ? lu_data : dbg_data;
            exp_we = (m_wb_g || m_lu_g || m_dbg_g) && (exp_ad != 0);
            exp_stall = dec_valid && ((dec_use1 && m_pend[dec_rs1]) ||
                                      (dec_use2 && m_pend[dec_rs2]) ||
                                      (dec_used && m_pend[dec_rd]));
            check("we3", 32'(we3), 32'(exp_we));
            if (exp_we) begin
                check("ad3", 32'(ad3), 32'(exp_ad));
                check("wd3", wd3, exp_wd);
            end
            check("lu_ready", 32'(lu_ready), 32'(m_lu_g));
            check("dbg_ready", 32'(dbg_ready), 32'(m_dbg_g));
            check("hazard_stall", 32'(hazard_stall), 32'(exp_stall));
            check("pipe_freeze", 32'(pipe_freeze), 32'(m_freeze));
            check("starve_cnt", 32'(starve_cnt), 32'(m_starve));
            check("sched_state", 32'(sched_state), 32'(m_freeze));
        end
    endtask

    // Clock edge: advance the model, leave the bench 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_pend = '0;
            m_starve = 0;
            m_freeze = 0;
        end else begin
            if (m_lu_g) m_pend[lu_rd] = 1'b0;
            if (lu_issue && lu_issue_rd != 0) m_pend[lu_issue_rd] = 1'b1;
            if (lu_valid && !m_lu_g) m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX;
            else m_starve = 0;
            m_freeze = !m_freeze && (m_starve == STARVE_MAX);
        end
        #1;
    endtask

    initial begin
        m_pend = '0; m_starve = 0; m_freeze = 0;
        m_wb_g = 0; m_lu_g = 0; m_dbg_g = 0;
        clear_inputs();
        rst = 1;
        @(posedge clk); #1;
        wb_valid = 1; wb_rd = 5; lu_valid = 1; lu_rd = 6; dbg_valid = 1; dbg_rd = 7;
        look(); tick();
        rst = 0;
        clear_inputs();
        look(); tick();

        // Priority: WB over LU over DBG, then LU, then DBG.
        wb_valid = 1; wb_rd = 5; wb_data = 32'h1111_0005;
        lu_valid = 1; lu_rd = 6; lu_data = 32'h2222_0006;
        dbg_valid = 1; dbg_rd = 7; dbg_data = 32'h3333_0007;
        look();
        check("t1_ad3_wb", 32'(ad3), 5);
        check("t1_lu_ready", 32'(lu_ready), 0);
        check("t1_dbg_ready", 32'(dbg_ready), 0);
        tick();
        wb_valid = 0;
        look();
        check("t1_ad3_lu", 32'(ad3), 6);
        tick();
        lu_valid = 0;
        look();
        check("t1_ad3_dbg", 32'(ad3), 7);
        tick();
        dbg_valid = 0;

        // RAW stall on a pending LU destination.
        lu_issue = 1; lu_issue_rd = 9;
        look(); tick();
        lu_issue = 0;
        dec_valid = 1; dec_rs1 = 9; dec_use1 = 1;
        for (int i = 0; i < 3; i++) begin
            look();
            check("t2_stall_wait", 32'(hazard_stall), 1);
            tick();
        end
        lu_valid = 1; lu_rd = 9; lu_data = 32'h0000_0909;
        look();
        check("t2_stall_hs", 32'(hazard_stall), 1);
        tick();
        lu_valid = 0;
        look();
        check("t2_stall_rel", 32'(hazard_stall), 0);
        tick();
        clear_inputs();

        // Starvation: eight refusals, then a freeze cycle that grants the LU.
        wb_valid = 1; wb_rd = 1; wb_data = 32'hAAAA_0001;
        lu_valid = 1; lu_rd = 12; lu_data = 32'hBBBB_000C;
        for (int i = 0; i < STARVE_MAX; i++) begin
            look();
            check("t3_denied", 32'(lu_ready), 0);
            check("t3_no_freeze", 32'(pipe_freeze), 0);
            tick();
        end
        look();
        check("t3_freeze", 32'(pipe_freeze), 1);
        check("t3_lu_ready", 32'(lu_ready), 1);
        check("t3_ad3", 32'(ad3), 12);
        tick();
        lu_valid = 0;
        look();
        check("t3_unfreeze", 32'(pipe_freeze), 0);
        check("t3_ad3_wb", 32'(ad3), 1);
        tick();
        clear_inputs();

        // Same-cycle issue and completion on rd 3: set wins.
        lu_issue = 1; lu_issue_rd = 3; lu_valid = 1; lu_rd = 3; lu_data = 32'h33;
        look(); tick();
        clear_inputs();
        dec_valid = 1; dec_rs1 = 3; dec_use1 = 1;
        look();
        check("t4_stall", 32'(hazard_stall), 1);
        tick();
        lu_valid = 1; lu_rd = 3;
        look(); tick();
        clear_inputs();

        // Debug write to x0.
        dbg_valid = 1; dbg_rd = 0; dbg_data = 32'hDEAD_BEEF;
        look();
        check("t5_dbg_ready", 32'(dbg_ready), 1);
        check("t5_we3", 32'(we3), 0);
        tick();
        clear_inputs();

        // Reset with pending[4] set and counter at 5.
        lu_issue = 1; lu_issue_rd = 4;
        look(); tick();
        lu_issue = 0;
        wb_valid = 1; wb_rd = 2; lu_valid = 1; lu_rd = 4;
        for (int i = 0; i < 5; i++) begin
            look(); tick();
        end
        check("t6_cnt_before", 32'(starve_cnt), 5);
        rst = 1;
        look(); tick();
        rst = 0;
        clear_inputs();
        dec_valid = 1; dec_rs1 = 4; dec_use1 = 1;
        look();
        check("t6_stall", 32'(hazard_stall), 0);
        check("t6_cnt", 32'(starve_cnt), 0);
        check("t6_state", 32'(sched_state), 0);
        tick();
        clear_inputs();

        // Random traffic, holding LU/DBG requests stable until accepted.
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 149) == 0);
            wb_valid = ($urandom_range(0, 3) != 0);
            wb_rd = ADDR_W'($urandom_range(0, 7));
            wb_data = $urandom;
            if (!lu_valid || m_lu_g || rst) begin
                lu_valid = ($urandom_range(0, 2) != 0);
                lu_rd = ADDR_W'($urandom_range(0, 7));
                lu_data = $urandom;
            end
            if (!dbg_valid || m_dbg_g || rst) begin
                dbg_valid = ($urandom_range(0, 3) == 0);
                dbg_rd = ADDR_W'($urandom_range(0, 7));
                dbg_data = $urandom;
            end
            lu_issue = ($urandom_range(0, 2) == 0);
            lu_issue_rd = ADDR_W'($urandom_range(0, 7));
            dec_valid = $urandom_range(0, 1);
            dec_rs1 = ADDR_W'($urandom_range(0, 7));
            dec_rs2 = ADDR_W'($urandom_range(0, 7));
            dec_rd = ADDR_W'($urandom_range(0, 7));
            dec_use1 = $urandom_range(0, 1);
            dec_use2 = $urandom_range(0, 1);
            dec_used = $urandom_range(0, 1);
            look(); tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
